// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS IF stage with one outstanding imem fetch, a PC+4 tagged queue,
// decode stall back-pressure and branch/jump redirect flush.
module instr_fetch_unit #(
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pcplus4
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW+1:0] QD = (AW+2)'(QDEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t r_state, w_next;
  logic [31:0] r_pc, r_pend;
  logic [31:0] r_instr [QDEPTH];
  logic [31:0] r_pc4 [QDEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0] r_count;
  logic w_accept, w_push, w_pop, w_wait;
  assign o_imem_addr  = {2'b00, r_pc[31:2]};
  assign o_if_valid   = r_count != '0;
  assign o_if_instr   = r_instr[r_head];
  assign o_if_pcplus4 = r_pc4[r_head];
  assign w_wait       = r_state == WAIT;
  // the in-flight fetch reserves a queue slot so a response can always be pushed
  always_comb begin
    o_imem_req = i_rst_n & !i_redirect & (({1'b0, r_count} + {{(AW+1){1'b0}}, w_wait}) < QD)
                 & (r_state == IDLE | (w_wait & i_imem_rvalid));
    w_accept = o_imem_req & i_imem_ready;
    w_push   = w_wait & i_imem_rvalid & !i_redirect;
    w_pop    = o_if_valid & !i_stall & !i_redirect;
    w_next   = i_redirect ? ((r_state != IDLE && !i_imem_rvalid) ? DISCARD : IDLE)
             : w_accept ? WAIT
             : (i_imem_rvalid && r_state != IDLE) ? IDLE : r_state;
  end
  always_ff @(posedge i_clk) r_state <= i_rst_n ? w_next : IDLE;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc   <= RESET_PC;
      r_pend <= '0;
    end else if (i_redirect) begin
      r_pc <= {i_redirect_pc[31:2], 2'b00};
    end else if (w_accept) begin
      r_pc   <= r_pc + 32'd4;
      r_pend <= r_pc + 32'd4;
    end
  end
  // flushed entries are zeroed so no pre-redirect instruction lingers on if_instr
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc4[i]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_instr[r_tail] <= i_imem_rdata;
        r_pc4[r_tail]   <= r_pend;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random stall/ready/latency/redirect/reset stimulus against a sequential
// instruction-stream model; a negedge monitor pops the expected stream as decode consumes.
module tb_instr_fetch_unit;
  localparam int QDEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 0, rst_n = 0, ready = 0, rvalid = 0, redirect = 0, stall = 0;
  logic [31:0] rdata = 0, redirect_pc = 0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pcplus4;
  instr_fetch_unit #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ready(ready), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_stall(stall),
    .o_if_valid(if_valid), .o_if_instr(if_instr), .o_if_pcplus4(if_pcplus4));
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc4;} ent_t;
  ent_t exp_q[$];
  int passed = 0, total = 0;
  logic [31:0] model_pc = RESET_PC;
  bit mem_busy = 0, mem_stale = 0, mem_rst_stale = 0, prev_redirect = 0;
  logic [31:0] mem_addr = 0;
  int mem_cnt = 0;
  function automatic logic [31:0] instr_at(input logic [31:0] byte_pc);
    return 32'h2000_0001 + byte_pc / 4;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // one clock cycle: entered and left at posedge+1
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rp, input bit rdy, input int lat);
    bit fire;
    logic exp_req;
    fire = mem_busy && mem_cnt == 0;
    if (mem_busy && mem_cnt != 0) mem_cnt--;
    rvalid = fire;
    rdata = fire ? 32'h2000_0001 + mem_addr : $urandom;
    stall = st;
    redirect = rd & rst_n;
    redirect_pc = rp;
    ready = rdy & !(mem_busy && mem_rst_stale && !fire);
    #1;
    if (prev_redirect) check("if_valid after redirect", {31'b0, if_valid}, 32'd0);
    prev_redirect = redirect;
    exp_req = rst_n && !redirect && exp_q.size() < QDEPTH &&
              (!mem_busy || mem_rst_stale || (fire && !mem_stale));
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (fire) begin mem_busy = 0; mem_stale = 0; mem_rst_stale = 0; end
    if (redirect) begin
      exp_q.delete();
      model_pc = rp & 32'hFFFF_FFFC;
      if (mem_busy) mem_stale = 1;
    end else if (imem_req && ready) begin
      check("imem_addr", imem_addr, model_pc >> 2);
      exp_q.push_back(ent_t'{instr: instr_at(model_pc), pc4: model_pc + 32'd4});
      model_pc += 32'd4;
      mem_busy = 1;
      mem_addr = imem_addr;
      mem_cnt = lat - 1;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int n);
    rst_n = 0;
    for (int k = 0; k < n; k++) begin
      cycle(0, 0, 0, 0, 1);
      exp_q.delete();
      model_pc = RESET_PC;
      if (mem_busy) begin mem_stale = 1; mem_rst_stale = 1; end
      check("reset imem_req", {31'b0, imem_req}, 32'd0);
      check("reset if_valid", {31'b0, if_valid}, 32'd0);
      check("reset if_instr", if_instr, 32'd0);
      check("reset if_pcplus4", if_pcplus4, 32'd0);
    end
    rst_n = 1;
  endtask
  always @(negedge clk) begin
    if (rst_n && !redirect && if_valid) begin
      if (exp_q.size() == 0) check("if_valid with empty model", {31'b0, if_valid}, 32'd0);
      else begin
        check("if_instr", if_instr, exp_q[0].instr);
        check("if_pcplus4", if_pcplus4, exp_q[0].pc4);
        if (!stall) void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    @(posedge clk);
    #1;
    do_reset(2);
    for (int c = 1; c <= 3; c++) begin
      check("first-fetch if_valid", {31'b0, if_valid}, {31'b0, c == 3});
      cycle(c == 3, 0, 0, 1, 1);
    end
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 1, 1);
    check("stall holds if_instr", if_instr, 32'h2000_0001);
    check("stall full drops req", {31'b0, imem_req}, 32'd0);
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 0, 1);
      check("addr held while not ready", imem_addr, model_pc >> 2);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 3);
    cycle(0, 1, 32'h0000_0103, 1, 1);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 3);
    do_reset(1);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 1, 2);
    cycle(0, 1, 32'hFFFF_FFF5, 1, 1);
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 1, 1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      else cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(1, 3));
    end
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0, 1);
    check("drained if_valid", {31'b0, if_valid}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
